// File: rtl/seq_log_pkg.sv
// Shared widths, the "no previous detection" gap marker and the event record layout
// for the detection logger.
package seq_log_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int GAP_W_DEF = 8;
    localparam int CNT_W_DEF = 16;
    localparam int DEPTH_DEF = 4;

    localparam logic [GAP_W_DEF-1:0] GAP_NONE = '1;

    // Event record: timestamp in the upper bits, gap in the lower bits.
    typedef struct packed {
        logic [TS_W_DEF-1:0]  ts;
        logic [GAP_W_DEF-1:0] gap;
    } evt_t;

    localparam int EVT_GAP_LSB = 0;
    localparam int EVT_TS_LSB  = EVT_GAP_LSB + GAP_W_DEF;

endpackage

// File: rtl/seq_evt_fifo.sv
// Synchronous event FIFO, registered head (no write-through), async reset plus sync clear.
// Pointers carry an extra wrap bit so full and empty are distinguishable at equal indices.
module seq_evt_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         pop_ok;
    logic         push_ok;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign level   = wr_q - rd_q;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + (AW+1)'(1);
            if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: the read port is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem_q[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/seq_detect_logger.sv
// Timestamps detector pulses, measures inter-detection gaps, queues events for a
// valid/ready consumer and keeps saturating detection/drop counters.
module seq_detect_logger
    import seq_log_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int GAP_W = GAP_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             det,
    input  logic             clear,
    input  logic             ev_ready,
    output logic             ev_valid,
    output logic [TS_W-1:0]  ev_ts,
    output logic [GAP_W-1:0] ev_gap,
    output logic [LW-1:0]    level,
    output logic [CNT_W-1:0] det_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow
);

    localparam int EW     = TS_W + GAP_W;
    localparam int TS_LSB = EVT_GAP_LSB + GAP_W;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [GAP_W-1:0] since_q, since_d;
    logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             ovf_q, ovf_d;

    logic          fifo_full, fifo_empty;
    logic          det_ok, pop, push, drop;
    logic [EW-1:0] rdata;

    // clear wins over everything: a det in that cycle is neither queued nor counted.
    assign det_ok   = det && !clear;
    assign ev_valid = !fifo_empty;
    assign pop      = ev_valid && ev_ready && !clear;
    assign push     = det_ok && (!fifo_full || pop);
    assign drop     = det_ok && fifo_full && !pop;

    always_comb begin
        ts_d       = ts_q + TS_W'(1);
        since_d    = since_q;
        det_cnt_d  = det_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (clear) begin
            since_d    = '1;
            det_cnt_d  = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (det_ok)             since_d = GAP_W'(1);
            else if (since_q != '1) since_d = since_q + GAP_W'(1);
            if (det_ok && det_cnt_q != '1) det_cnt_d = det_cnt_q + CNT_W'(1);
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q       <= '0;
            since_q    <= '1;
            det_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            since_q    <= since_d;
            det_cnt_q  <= det_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    seq_evt_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .clr   (clear),
        .push  (push),
        .pop   (pop),
        .wdata ({ts_q, since_q}),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign ev_ts      = rdata[TS_LSB +: TS_W];
    assign ev_gap     = rdata[EVT_GAP_LSB +: GAP_W];
    assign det_count  = det_cnt_q;
    assign drop_count = drop_cnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_seq_detect_logger.sv
// Randomized plus directed bench for seq_detect_logger: queue-based reference model,
// scoreboard of expected events consumed by a negedge monitor.
module tb_seq_detect_logger;
    import seq_log_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        det = 1'b0;
    logic        clear = 1'b0;
    logic        ev_ready = 1'b0;
    logic        ev_valid;
    logic [15:0] ev_ts;
    logic [7:0]  ev_gap;
    logic [2:0]  level;
    logic [15:0] det_count;
    logic [15:0] drop_count;
    logic        overflow;

    seq_detect_logger dut (
        .clk        (clk),
        .reset      (reset),
        .det        (det),
        .clear      (clear),
        .ev_ready   (ev_ready),
        .ev_valid   (ev_valid),
        .ev_ts      (ev_ts),
        .ev_gap     (ev_gap),
        .level      (level),
        .det_count  (det_count),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct { int ts; int gap; } ev_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc;
    int  last_det;
    int  m_det, m_drop;
    bit  m_ovf;
    ev_t mq[$];
    ev_t exp_q[$];
    int  s_level, s_det, s_drop;
    bit  s_ovf, s_valid;
    bit  chk_en = 1'b0;
    ev_t mon_e;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_init();
        cyc = 0; last_det = -1; m_det = 0; m_drop = 0; m_ovf = 0;
        mq.delete(); exp_q.delete();
    endtask

    // Drive one cycle; called just after a rising edge. Snapshot what the DUT should
    // show this cycle, then apply the rules for the edge that ends it.
    task automatic step(input bit d, input bit rdy, input bit clr);
        ev_t e;
        bit  p;
        det = d; ev_ready = rdy; clear = clr;
        s_level = mq.size(); s_valid = (mq.size() > 0);
        s_det = m_det; s_drop = m_drop; s_ovf = m_ovf;
        if (clr) begin
            mq.delete(); exp_q.delete();
            m_det = 0; m_drop = 0; m_ovf = 0; last_det = -1;
        end else begin
            p = (mq.size() > 0) && rdy;
            if (d) begin
                e.ts  = cyc % 65536;
                e.gap = (last_det < 0) ? 255 : ((cyc - last_det) > 255 ? 255 : cyc - last_det);
                last_det = cyc;
                if (m_det < 65535) m_det++;
                if (mq.size() < DEPTH || p) begin
                    mq.push_back(e);
                    exp_q.push_back(e);
                end else begin
                    if (m_drop < 65535) m_drop++;
                    m_ovf = 1;
                end
            end
            if (p) void'(mq.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        chk_en = 0;
        #2 reset = 1'b1;
        det = 0; clear = 0; ev_ready = 0;
        #1;
        chk("rst_valid", ev_valid, 0);
        chk("rst_ts", ev_ts, 0);
        chk("rst_gap", ev_gap, 0);
        chk("rst_level", level, 0);
        chk("rst_det_count", det_count, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_init();
        chk_en = 1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", ev_valid, s_valid);
            chk("level", level, s_level);
            chk("det_count", det_count, s_det);
            chk("drop_count", drop_count, s_drop);
            chk("overflow", overflow, s_ovf);
            if (!ev_valid) begin
                chk("idle_ts", ev_ts, 0);
                chk("idle_gap", ev_gap, 0);
            end else if (ev_ready && !clear) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ev_ts", ev_ts, mon_e.ts);
                    chk("ev_gap", ev_gap, mon_e.gap);
                end
            end
        end
    end

    initial begin
        bit [3:0] sh;
        bit [7:0] pat;
        int       bit_i;

        // Two detections, consumer always ready.
        do_reset();
        for (int c = 0; c < 13; c++) begin
            if (c == 5) chk("t1_no_bypass", ev_valid, 0);
            if (c == 6) begin
                chk("t1_valid_c6", ev_valid, 1);
                chk("t1_ts_c6", ev_ts, 5);
                chk("t1_gap_c6", ev_gap, GAP_NONE);
            end
            if (c == 10) begin
                chk("t1_ts_c10", ev_ts, 9);
                chk("t1_gap_c10", ev_gap, 4);
            end
            step(c == 5 || c == 9, 1, 0);
        end
        chk("t1_det_count", det_count, 2);
        chk("t1_drop_count", drop_count, 0);

        // Fill with consumer stalled; fifth detection is dropped.
        do_reset();
        for (int c = 0; c < 11; c++) begin
            step(c >= 2 && c % 2 == 0, 0, 0);
            if (c == 9) chk("t2_head_stable", ev_ts, 2);
        end
        chk("t2_level", level, 4);
        chk("t2_drop", drop_count, 1);
        chk("t2_ovf", overflow, 1);
        chk("t2_det", det_count, 5);

        // Full FIFO, push and pop in the same cycle.
        step(1, 1, 0);
        chk("t3_level", level, 4);
        chk("t3_drop", drop_count, 1);
        chk("t3_head", ev_ts, 4);
        for (int c = 0; c < 6; c++) step(0, 1, 0);
        chk("t3_drained", level, 0);

        // Gap saturation and back-to-back detections.
        step(1, 1, 0);
        for (int c = 0; c < 299; c++) step(0, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        for (int c = 0; c < 4; c++) step(0, 1, 0);

        // clear together with det while two events are held.
        step(1, 0, 0);
        step(1, 0, 0);
        chk("t5_level_pre", level, 2);
        step(1, 0, 1);
        chk("t5_level", level, 0);
        chk("t5_valid", ev_valid, 0);
        chk("t5_det", det_count, 0);
        chk("t5_ovf", overflow, 0);
        step(1, 1, 0);
        chk("t5_gap_after_clear", ev_gap, GAP_NONE);
        step(0, 1, 0);

        // Asynchronous reset mid-stream; timestamp restarts.
        step(1, 0, 0);
        step(1, 0, 0);
        do_reset();
        for (int c = 0; c < 4; c++) step(c == 3, 0, 0);
        chk("t6_ts_restart", ev_ts, 3);
        for (int c = 0; c < 3; c++) step(0, 1, 0);

        // End-to-end with a 1100 detector model.
        do_reset();
        sh = '0;
        pat = 8'b11001100;
        for (int c = 0; c < 14; c++) begin
            bit_i = (c >= 1 && c <= 8) ? pat[8 - c] : 0;
            sh = {sh[2:0], bit_i[0]};
            step(sh == 4'b1100, 1, 0);
        end
        chk("t7_det", det_count, 2);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            step($urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < ((c / 250) % 2 == 0 ? 30 : 80),
                 $urandom_range(0, 199) < 3);
        end
        for (int c = 0; c < DEPTH + 3; c++) step(0, 1, 0);
        chk("sb_empty", exp_q.size(), 0);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_logger.md
Name: seq_detect_logger

Overview:
- Downstream consumer of the serial sequence detector's one-cycle match pulse (the detector output, e.g. for pattern 1100).
- Timestamps every detection with a free-running cycle counter and measures the gap since the previous detection.
- Buffers events in a small FIFO with a valid/ready drain port, and keeps saturating detection and drop counters for status readout.

Parameters:
- TS_W, 16, width of free-running timestamp counter and ev_ts
- GAP_W, 8, width of inter-detection gap field, saturating
- CNT_W, 16, width of det_count and drop_count, saturating
- DEPTH, 4, event FIFO entries; power of two, >=2

Ports:
- clk  input  1  rising-edge clock, one serial bit per cycle
- reset  input  1  asynchronous, active-high; clears all state
- det  input  1  detection pulse from the sequence detector, sampled every clk edge
- clear  input  1  synchronous clear of FIFO, counters, gap tracker and overflow; ts is not cleared
- ev_ready  input  1  consumer ready
- ev_valid  output  1  FIFO head valid
- ev_ts  output  TS_W  timestamp of head event
- ev_gap  output  GAP_W  gap of head event
- level  output  clog2(DEPTH)+1  FIFO occupancy
- det_count  output  CNT_W  accepted plus dropped detections, saturating
- drop_count  output  CNT_W  detections lost to full FIFO, saturating
- overflow  output  1  sticky; set on first drop

Behaviour:
- Reset, asynchronous: ts=0, since_cnt=all-ones, FIFO empty, ev_valid=0, ev_ts=0, ev_gap=0, level=0, det_count=0, drop_count=0, overflow=0.
- Timestamp: ts increments by 1 every edge and wraps 2^TS_W-1 -> 0.
  - "Cycle N" is the cycle in which ts==N.
  - A det sampled in cycle N captures ts=N.
- Gap tracker since_cnt:
  - On det: captured gap=since_cnt, then since_cnt<=1.
  - Otherwise since_cnt<=min(since_cnt+1, 2^GAP_W-1).
  - First detection after reset/clear reports gap=all-ones (none).
  - Gap is tracked on every det, including dropped ones.
- Push: det=1 and (not full, or pop in the same cycle) -> write {ts, gap}.
  - Full with simultaneous pop: the push is accepted and level is unchanged.
- Drop: det=1, full, no pop -> event discarded; drop_count+1 (saturating); overflow<=1.
- det_count: +1 (saturating) on every det, whether accepted or dropped.
- Pop: ev_valid && ev_ready. Head advances at the edge; the next entry appears the following cycle.
- Latency:
  - det in cycle N -> ev_valid=1 in cycle N+1 when the FIFO was empty. No same-cycle bypass.
  - ev_ts/ev_gap are stable while ev_valid=1 and ev_ready=0.
- ev_ts/ev_gap read 0 when the FIFO is empty.
- Pointers: log2(DEPTH) index bits plus a wrap bit. Full = indices equal and wrap bits differ.
- Simultaneous push and pop with the FIFO empty: no pop occurs (ev_valid=0); the push proceeds.
- clear:
  - Synchronous; has priority over det, push and pop in the same cycle.
  - A det in the clear cycle is discarded and not counted.
  - Effects: FIFO empty, counters 0, since_cnt=all-ones, overflow=0.
- Reset mid-operation: all state returns to reset values immediately. In-flight events are lost.

Decomposition:
- Package seq_log_pkg: TS_W/GAP_W/CNT_W defaults, GAP_NONE (all-ones) constant, event record layout {ts, gap} with field offsets.
- One sub-module, seq_evt_fifo: parameterised synchronous FIFO (width TS_W+GAP_W, DEPTH) with push/pop/full/empty/level and async reset.
- Timestamp, gap tracker and counters stay in the top level.

Test Plan:
- Reset release, det in cycles 5 and 9, ev_ready=1 -> events {ts=5, gap=255} seen in cycle 6, {ts=9, gap=4} seen in cycle 10; det_count=2, drop_count=0.
- ev_ready=0; det in cycles 2,4,6,8,10 (DEPTH=4) -> level reaches 4; 5th det dropped; drop_count=1, overflow=1, det_count=5; then ev_ready=1 drains ts 2,4,6,8 in order with gaps 255,2,2,2.
- FIFO full; det and pop in the same cycle -> push accepted, level stays 4, drop_count unchanged, new entry ts at tail.
- Gap saturation: dets 300 cycles apart -> second event gap=255; dets in consecutive cycles 20,21 -> gap=1.
- clear asserted together with det while FIFO holds 2 events -> next cycle level=0, ev_valid=0, counters 0, overflow 0; following det reports gap=255.
- Async reset asserted mid-stream between edges -> all outputs 0 immediately; ts restarts at 0.
- End-to-end: chain the 1100 detector, drive ip 1,1,0,0,1,1,0,0 from cycle 1 -> two events spaced 4 cycles, second gap=4.
